// File: rtl/display_shift_driver_v3.sv
// Serial display driver: shifts a parallel frame into an external shift chain,
// then strobes the latch. Optional PWM blanking via DISPLAY_DRIVER_PWM_EN.
module display_shift_driver_v3 #(
   parameter int NUM_DIGITS     = 4,
   parameter int BITS_PER_DIGIT = 8,
   parameter int CLK_DIV        = 4,
   parameter int MSB_FIRST      = 1
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_DIGITS*BITS_PER_DIGIT-1:0] data_in,
   input  logic                                 load,
`ifdef DISPLAY_DRIVER_PWM_EN
   input  logic [3:0]                           brightness,
   output logic                                 oe_n,
`endif
   output logic                                 busy,
   output logic                                 done,
   output logic                                 serial_out,
   output logic                                 clk_out,
   output logic                                 latch_out
);

   localparam int TOTAL = NUM_DIGITS * BITS_PER_DIGIT;
   localparam int DW    = $clog2(CLK_DIV) + 1;
   localparam int CW    = $clog2(TOTAL) + 1;

   generate
      if (TOTAL < 1 || CLK_DIV < 1) begin : g_param_check
         $error("display_shift_driver_v3: TOTAL and CLK_DIV must both be >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

   state_t           state, state_nxt;
   logic [TOTAL-1:0] sreg;
   logic [TOTAL-1:0] pend_buf;
   logic             pending;
   logic [DW-1:0]    div;
   logic [CW-1:0]    bitcnt;
   logic             div_last;
   logic             restart;
   logic             cur_bit;

   assign div_last = (div == DW'(CLK_DIV - 1));
   assign cur_bit  = (MSB_FIRST != 0) ? sreg[TOTAL-1] : sreg[0];
   // a load on the LATCH exit edge counts as queued and starts at once
   assign restart  = load || pending;

   always_comb begin
      state_nxt  = state;
      busy       = 1'b0;
      serial_out = 1'b0;
      clk_out    = 1'b0;
      latch_out  = 1'b0;
      case (state)
         IDLE: begin
            if (load) state_nxt = SHIFT_LO;
         end
         SHIFT_LO: begin
            busy       = 1'b1;
            serial_out = cur_bit;
            if (div_last) state_nxt = SHIFT_HI;
         end
         SHIFT_HI: begin
            busy       = 1'b1;
            serial_out = cur_bit;
            clk_out    = 1'b1;
            if (div_last) state_nxt = (bitcnt == '0) ? LATCH : SHIFT_LO;
         end
         LATCH: begin
            busy      = 1'b1;
            latch_out = 1'b1;
            if (div_last) state_nxt = restart ? SHIFT_LO : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         sreg     <= '0;
         pend_buf <= '0;
         pending  <= 1'b0;
         div      <= '0;
         bitcnt   <= '0;
         done     <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= 1'b0;
         div   <= (div_last || state == IDLE) ? '0 : div + 1'b1;
         if (load && state != IDLE) begin
            pend_buf <= data_in;
            pending  <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (load) begin
                  sreg   <= data_in;
                  bitcnt <= CW'(TOTAL - 1);
               end
            end
            SHIFT_HI: begin
               if (div_last && bitcnt != '0) begin
                  sreg   <= (MSB_FIRST != 0) ? (sreg << 1) : (sreg >> 1);
                  bitcnt <= bitcnt - 1'b1;
               end
            end
            LATCH: begin
               if (div_last) begin
                  done <= 1'b1;
                  if (restart) begin
                     sreg    <= load ? data_in : pend_buf;
                     bitcnt  <= CW'(TOTAL - 1);
                     pending <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef DISPLAY_DRIVER_PWM_EN
   logic [3:0] pwm_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         pwm_cnt <= '0;
         oe_n    <= 1'b1;
      end else begin
         pwm_cnt <= pwm_cnt + 4'd1;
         oe_n    <= (state_nxt == LATCH) || !(pwm_cnt < brightness);
      end
   end
`endif

endmodule
